// File: rtl/rv_pkg.sv
// Shared RV front-end definitions: widths, PC step, reset PC default,
// the fetch FIFO entry layout and small PC helpers.
package rv_pkg;

    localparam int XLEN    = 32;
    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(PC_STEP);
    endfunction

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous DEPTH x {pc, inst} FIFO with push, pop and clear.
// Ports: clk, reset (async high), clear_i, push_i, pop_i, wdata_i,
//        rdata_o (head), empty_o, count_o.
module ifetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A push into a full FIFO is legal only together with a pop.
    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = ptr_next(wptr_q);
            if (do_pop)  rptr_d = ptr_next(rptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(push_i && !clear_i && !pop_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-order
// response buffering, redirect flush with stale-response dropping.
// Ports: clk, reset, current_pc/next_pc (PC reg), req_* (imem request),
//        rsp_* (imem response), redirect_* (execute), inst_* (decode).
module ifetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic [31:0] next_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     used;
    logic            fifo_empty;
    logic            hs, push, pop;
    logic [XLEN-1:0] tgt;
    fetch_entry_t    wdata, rdata;
    logic            unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];

    assign tgt  = pc_align(redirect_pc);
    assign used = {1'b0, fifo_cnt} + {1'b0, out_q};

    assign req_valid = !reset && !redirect_valid
                    && (used < (CW+1)'(DEPTH));
    assign req_addr  = current_pc;
    assign hs        = req_valid & req_ready;

    // Responses in the redirect cycle are stale by definition.
    assign push = rsp_valid && (drop_q == '0) && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        next_pc   = current_pc;
        out_d     = out_q + CW'(hs) - CW'(rsp_valid);
        drop_d    = drop_q;
        resp_pc_d = resp_pc_q;
        if (reset) begin
            next_pc = RESET_PC;
        end else if (redirect_valid) begin
            next_pc   = tgt;
            resp_pc_d = tgt;
            drop_d    = out_q - CW'(rsp_valid);
        end else begin
            if (hs) next_pc = pc_inc(current_pc);
            if (rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
            if (push) resp_pc_d = pc_inc(resp_pc_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            drop_q    <= '0;
            resp_pc_q <= RESET_PC;
        end else begin
            out_q     <= out_d;
            drop_q    <= drop_d;
            resp_pc_q <= resp_pc_d;
        end
    end

    assign wdata.pc   = resp_pc_q;
    assign wdata.inst = rsp_data;

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign inst_valid = !reset && !fifo_empty;
    assign inst_data  = rdata.inst;
    assign inst_pc    = rdata.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: PC register and in-order imem model
// with programmable latency, request/decode stream checking.
module tb_ifetch_unit;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] current_pc, next_pc, req_addr, rsp_data;
    logic [31:0] redirect_pc, inst_data, inst_pc;
    logic        req_valid, req_ready, rsp_valid;
    logic        redirect_valid, inst_valid, inst_ready;

    typedef struct {
        logic [31:0] addr;
        int          acc;
    } req_t;

    req_t        mq[$];
    int          cyc, lat, checks, errors, pops, reqs, base;
    logic [31:0] exp_req, exp_inst, saved;
    bit          hit;

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) current_pc <= 32'h0;
        else       current_pc <= next_pc;
    end

    ifetch_unit #(
        .RESET_PC (32'h0),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .current_pc     (current_pc),
        .next_pc        (next_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs sampled on the
    // falling edge, where the coming handshakes are already settled.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            if (req_valid && req_ready) begin
                chk("req_addr", req_addr, exp_req);
                exp_req += 32'd4;
                mq.push_back('{req_addr, cyc + 1});
                reqs++;
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                chk("inst_pc", inst_pc, exp_inst);
                chk("inst_data", inst_data, memf(exp_inst));
                exp_inst += 32'd4;
                pops++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        if (reset) begin
            mq.delete();
        end else if (mq.size() > 0 && mq[0].acc + lat <= cyc + 1) begin
            rsp_valid = 1'b1;
            rsp_data  = memf(mq[0].addr);
            void'(mq.pop_front());
        end
    endtask

    initial begin
        checks = 0; errors = 0; pops = 0; reqs = 0; cyc = 0; lat = 1;
        reset = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        rsp_valid = 1'b0; rsp_data = 32'h0;
        exp_req = 32'h0; exp_inst = 32'h0;

        // Reset state
        repeat (2) tick();
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_next_pc", next_pc, 32'h0);
        chk("rst_current_pc", current_pc, 32'h0);
        reset = 1'b0;

        // 1: streaming with 1-cycle memory
        repeat (16) tick();
        chk("t1_pops", 32'(pops >= 6), 32'd1);
        chk("t1_reqs", 32'(reqs >= 6), 32'd1);

        // 2: decode stalled, FIFO fills, credits exhausted
        inst_ready = 1'b0;
        repeat (5) tick();
        chk("t2_inst_valid", 32'(inst_valid), 32'd1);
        chk("t2_req_valid", 32'(req_valid), 32'd0);
        chk("t2_no_inflight", 32'(mq.size() == 0 && !rsp_valid), 32'd1);
        base = pops;
        inst_ready = 1'b1;
        repeat (6) tick();
        chk("t2_drained", 32'(pops >= base + 2), 32'd1);

        // 3: latency 3, redirect with two requests in flight
        lat = 3;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            hit = (mq.size() == 2);
        end
        chk("t3_two_outstanding", 32'(hit), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("t3_redir_req_valid", 32'(req_valid), 32'd0);
        chk("t3_redir_next_pc", next_pc, 32'h100);
        exp_req = 32'h100;
        exp_inst = 32'h100;
        base = pops;
        tick();
        redirect_valid = 1'b0;
        repeat (12) tick();
        chk("t3_resumed", 32'(pops > base), 32'd1);

        // 4: misaligned redirect coinciding with a response
        lat = 2;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            tick();
            hit = rsp_valid && (mq.size() >= 1);
        end
        chk("t4_rsp_and_inflight", 32'(hit), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        #1;
        chk("t4_redir_next_pc", next_pc, 32'h100);
        chk("t4_redir_req_valid", 32'(req_valid), 32'd0);
        exp_req = 32'h100;
        exp_inst = 32'h100;
        base = pops;
        tick();
        redirect_valid = 1'b0;
        repeat (12) tick();
        chk("t4_resumed", 32'(pops > base), 32'd1);

        // 5: imem backpressure
        lat = 1;
        req_ready = 1'b0;
        repeat (3) tick();
        saved = req_addr;
        base = reqs;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_req_valid", 32'(req_valid), 32'd1);
            chk("t5_req_addr", req_addr, saved);
            chk("t5_next_pc_hold", next_pc, current_pc);
        end
        chk("t5_no_reqs", 32'(reqs), 32'(base));
        req_ready = 1'b1;
        repeat (8) tick();
        chk("t5_resumed", 32'(reqs > base), 32'd1);

        // 6: asynchronous reset between edges
        inst_ready = 1'b0;
        repeat (4) tick();
        chk("t6_pre_inst_valid", 32'(inst_valid), 32'd1);
        #2;
        reset = 1'b1;
        exp_req = 32'h0;
        exp_inst = 32'h0;
        #1;
        chk("t6_req_valid", 32'(req_valid), 32'd0);
        chk("t6_inst_valid", 32'(inst_valid), 32'd0);
        chk("t6_next_pc", next_pc, 32'h0);
        chk("t6_current_pc", current_pc, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        inst_ready = 1'b1;
        base = pops;
        repeat (10) tick();
        chk("t6_restarted", 32'(pops > base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
